switch_mcu_regfile: RTL and testbench

General-purpose register file of the switch MCU core. It holds the 32×32-bit integer registers, with x0 hard-wired to zero. It serves two registered read ports and one write port to the ALU operation units, such as ORI and the other I/R-type units, which issue reads and writes under the decoder's `in_cycle_cnt` sequencing. The block sits directly downstream of the ALU units' register-access ports and supplies their `in_rdata_*` inputs.

---
 rtl/switch_mcu_pkg.sv | 15 +
 rtl/switch_mcu_regfile_if.sv | 35 +++
 rtl/switch_mcu_regfile_rport.sv | 60 ++++++
 rtl/switch_mcu_regfile.sv | 69 ++++++
 tb/tb_switch_mcu_regfile.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/switch_mcu_pkg.sv
// Shared switch MCU core types: register data/address widths and the x0 index.
// Latency: none (types and constants only).
// Backpressure: none.
package switch_mcu_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int REG_NUM = 1 << REG_AW;

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/switch_mcu_regfile_if.sv
// Register-file access bundle between the ALU units (master) and the regfile (slave).
// Latency: none (wires only).
// Backpressure: none; reads and writes are always accepted.
interface switch_mcu_regfile_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);

  logic              in_ren_1;
  logic [REG_AW-1:0] in_raddr_1;
  logic [XLEN-1:0]   out_rdata_1;
  logic              out_rvalid_1;

  logic              in_ren_2;
  logic [REG_AW-1:0] in_raddr_2;
  logic [XLEN-1:0]   out_rdata_2;
  logic              out_rvalid_2;

  logic              in_wen;
  logic [REG_AW-1:0] in_waddr;
  logic [XLEN-1:0]   in_wdata;

  modport master (
    output in_ren_1, in_raddr_1, in_ren_2, in_raddr_2,
    output in_wen, in_waddr, in_wdata,
    input  out_rdata_1, out_rvalid_1, out_rdata_2, out_rvalid_2
  );

  modport slave (
    input  in_ren_1, in_raddr_1, in_ren_2, in_raddr_2,
    input  in_wen, in_waddr, in_wdata,
    output out_rdata_1, out_rvalid_1, out_rdata_2, out_rvalid_2
  );

endinterface

// File: rtl/switch_mcu_regfile_rport.sv
// One registered read port: x0 mux, optional same-edge write forwarding, data/valid flops.
// Latency: 1 cycle from request edge to rdata/rvalid; rdata holds when no request.
// Backpressure: none; every request edge reloads the port.
// Forwarding is compiled in when SWITCH_MCU_REGFILE_BYPASS_EN is defined (else read-first).
module switch_mcu_regfile_rport
  import switch_mcu_pkg::*;
#(
  parameter int XLEN   = switch_mcu_pkg::XLEN,
  parameter int REG_AW = switch_mcu_pkg::REG_AW
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          ren,
  input  logic [REG_AW-1:0]             raddr,
  input  logic [(1<<REG_AW)*XLEN-1:0]   regs_flat,
  input  logic                          byp_wen,
  input  logic [REG_AW-1:0]             byp_waddr,
  input  logic [XLEN-1:0]               byp_wdata,
  output logic [XLEN-1:0]               rdata,
  output logic                          rvalid
);

  logic [XLEN-1:0] rd_next;
  logic            is_zero;

  assign is_zero = (raddr == REG_AW'(REG_ZERO));

`ifndef SWITCH_MCU_REGFILE_BYPASS_EN
  // Read-first build: the write bus is not consulted by the read path.
  logic unused_byp;
  assign unused_byp = ^{byp_wen, byp_waddr, byp_wdata};
`endif

  // Select the value this port loads: x0 is always zero, optionally forward a same-edge write.
  always_comb begin
    rd_next = regs_flat[int'(raddr)*XLEN +: XLEN];
    if (is_zero) begin
      rd_next = '0;
    end
`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
    if (byp_wen && (byp_waddr == raddr) && !is_zero) begin
      rd_next = byp_wdata;
    end
`endif
  end

  // Output flops: data reloads only on request so ALU units can sample it later.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ren;
      if (ren) begin
        rdata <= rd_next;
      end
    end
  end

endmodule

// File: rtl/switch_mcu_regfile.sv
// Switch MCU integer register file: x1..x31 flops, x0 reads zero, two registered read ports.
// Latency: write visible to reads sampled one edge later; reads return 1 cycle after request.
// Backpressure: none. Same-edge read/write forwarding under SWITCH_MCU_REGFILE_BYPASS_EN.
module switch_mcu_regfile #(
  parameter int XLEN   = switch_mcu_pkg::XLEN,
  parameter int REG_AW = switch_mcu_pkg::REG_AW
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  switch_mcu_regfile_if.slave  bus
);

  import switch_mcu_pkg::*;

  localparam int NREG = 1 << REG_AW;

  logic [XLEN-1:0]      regs [1:NREG-1];
  logic [NREG*XLEN-1:0] regs_flat;

  // Write decoder: one-hot enable per stored register; x0 has no storage so its writes vanish.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (bus.in_wen && (bus.in_waddr == REG_AW'(i)) && (bus.in_waddr != REG_AW'(REG_ZERO))) begin
          regs[i] <= bus.in_wdata;
        end
      end
    end
  end

  // Flatten storage for the read ports; slot 0 is a constant zero.
  always_comb begin
    regs_flat = '0;
    for (int i = 1; i < NREG; i++) begin
      regs_flat[i*XLEN +: XLEN] = regs[i];
    end
  end

  switch_mcu_regfile_rport #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rport_1 (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .ren       (bus.in_ren_1),
    .raddr     (bus.in_raddr_1),
    .regs_flat (regs_flat),
    .byp_wen   (bus.in_wen),
    .byp_waddr (bus.in_waddr),
    .byp_wdata (bus.in_wdata),
    .rdata     (bus.out_rdata_1),
    .rvalid    (bus.out_rvalid_1)
  );

  switch_mcu_regfile_rport #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rport_2 (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .ren       (bus.in_ren_2),
    .raddr     (bus.in_raddr_2),
    .regs_flat (regs_flat),
    .byp_wen   (bus.in_wen),
    .byp_waddr (bus.in_waddr),
    .byp_wdata (bus.in_wdata),
    .rdata     (bus.out_rdata_2),
    .rvalid    (bus.out_rvalid_2)
  );

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Self-checking bench for switch_mcu_regfile: directed literal cases plus randomized traffic.
// A register-array model predicts both read ports every cycle out of reset.
module tb_switch_mcu_regfile;

`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic in_clk;
  logic in_rst;

  switch_mcu_regfile_if #(.XLEN(32), .REG_AW(5)) rf_if ();

  switch_mcu_regfile #(.XLEN(32), .REG_AW(5)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (rf_if.slave)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and what each port should show.
  logic [31:0] mem [32];
  logic [31:0] exp_rd1, exp_rd2;
  logic        exp_v1, exp_v2;

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (BYP && w && (wa == a)) return wd;
    return mem[a];
  endfunction

  always @(posedge in_clk) begin
    if (!in_rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      exp_rd1 = 32'd0; exp_rd2 = 32'd0; exp_v1 = 1'b0; exp_v2 = 1'b0;
    end else begin
      exp_v1 = rf_if.in_ren_1;
      exp_v2 = rf_if.in_ren_2;
      if (rf_if.in_ren_1) exp_rd1 = model_read(rf_if.in_raddr_1, rf_if.in_wen, rf_if.in_waddr, rf_if.in_wdata);
      if (rf_if.in_ren_2) exp_rd2 = model_read(rf_if.in_raddr_2, rf_if.in_wen, rf_if.in_waddr, rf_if.in_wdata);
      if (rf_if.in_wen && rf_if.in_waddr != 5'd0) mem[rf_if.in_waddr] = rf_if.in_wdata;
    end
    #1;
    if (in_rst) begin
      chk("model_rdata_1",  rf_if.out_rdata_1, exp_rd1);
      chk("model_rvalid_1", {31'd0, rf_if.out_rvalid_1}, {31'd0, exp_v1});
      chk("model_rdata_2",  rf_if.out_rdata_2, exp_rd2);
      chk("model_rvalid_2", {31'd0, rf_if.out_rvalid_2}, {31'd0, exp_v2});
    end
  end

  task automatic step(input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                      input logic w, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge in_clk);
    rf_if.in_ren_1 = r1; rf_if.in_raddr_1 = a1;
    rf_if.in_ren_2 = r2; rf_if.in_raddr_2 = a2;
    rf_if.in_wen = w; rf_if.in_waddr = wa; rf_if.in_wdata = wd;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic settle();
    @(posedge in_clk);
    #2;
  endtask

  logic [31:0] col_exp;
  logic [31:0] ori_src;

  initial begin
    in_rst = 1'b0;
    rf_if.in_ren_1 = 1'b0; rf_if.in_raddr_1 = '0;
    rf_if.in_ren_2 = 1'b0; rf_if.in_raddr_2 = '0;
    rf_if.in_wen = 1'b0; rf_if.in_waddr = '0; rf_if.in_wdata = '0;
    repeat (3) @(posedge in_clk);
    #2;
    chk("reset_rdata_1", rf_if.out_rdata_1, 32'd0);
    chk("reset_rvalid_1", {31'd0, rf_if.out_rvalid_1}, 32'd0);
    chk("reset_rdata_2", rf_if.out_rdata_2, 32'd0);
    chk("reset_rvalid_2", {31'd0, rf_if.out_rvalid_2}, 32'd0);
    @(negedge in_clk);
    in_rst = 1'b1;

    // Basic write then read, then hold with ren low.
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678);
    step(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    settle();
    chk("basic_rdata", rf_if.out_rdata_1, 32'h12345678);
    chk("basic_rvalid", {31'd0, rf_if.out_rvalid_1}, 32'd1);
    idle();
    settle();
    chk("basic_rvalid_drop", {31'd0, rf_if.out_rvalid_1}, 32'd0);
    chk("basic_hold", rf_if.out_rdata_1, 32'h12345678);

    // x0 ignores writes, both ports read zero, also on a same-edge x0 write.
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    settle();
    chk("x0_port1", rf_if.out_rdata_1, 32'd0);
    chk("x0_port2", rf_if.out_rdata_2, 32'd0);

    // Dual-port independent reads.
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h00000AAA);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h00000555);
    step(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
    settle();
    chk("dual_port1", rf_if.out_rdata_1, 32'h00000AAA);
    chk("dual_port2", rf_if.out_rdata_2, 32'h00000555);
    step(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
    settle();
    chk("same_addr_p1", rf_if.out_rdata_1, 32'h00000555);
    chk("same_addr_p2", rf_if.out_rdata_2, 32'h00000555);

    // Collision: read and write x9 on the same edge.
    col_exp = BYP ? 32'h22222222 : 32'h11111111;
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h11111111);
    step(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 32'h22222222);
    settle();
    chk("collision_p1", rf_if.out_rdata_1, col_exp);
    chk("collision_p2", rf_if.out_rdata_2, col_exp);
    step(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    settle();
    chk("collision_after", rf_if.out_rdata_1, 32'h22222222);

    // ORI-style sequence: read rs1 at cnt 1, compute, write rd at cnt 4.
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 32'h0000F000);
    idle();                                              // cnt 0
    step(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);     // cnt 1
    idle();                                              // cnt 2
    idle();                                              // cnt 3
    ori_src = rf_if.out_rdata_1;
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, ori_src | 32'h000000FF); // cnt 4
    step(1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0);
    settle();
    chk("ori_result", rf_if.out_rdata_2, 32'h0000F0FF);

    // Reset mid-operation clears state immediately and drops in-flight traffic.
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    settle();
    chk("pre_reset_x5", rf_if.out_rdata_1, 32'hDEADBEEF);
    step(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 32'hCAFEF00D);
    #3;
    in_rst = 1'b0;
    #1;
    chk("midrst_rdata_1", rf_if.out_rdata_1, 32'd0);
    chk("midrst_rvalid_1", {31'd0, rf_if.out_rvalid_1}, 32'd0);
    chk("midrst_rdata_2", rf_if.out_rdata_2, 32'd0);
    idle();
    @(negedge in_clk);
    in_rst = 1'b1;
    step(1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0);
    settle();
    chk("post_reset_x5", rf_if.out_rdata_1, 32'h00000000);
    chk("post_reset_x6", rf_if.out_rdata_2, 32'h00000000);

    // Randomized traffic, addresses biased low to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a1, a2, wa;
      a1 = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      a2 = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      wa = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      step(1'($urandom_range(1)), a1, 1'($urandom_range(1)), a2,
           1'($urandom_range(1)), wa, $urandom);
    end
    idle();
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
